register_bank_sb: RTL

Parametrised successor of the processor's register bank: a DEPTH×DATA_W register file with two combinational read ports and one byte-enabled write port. It adds an optional hardwired-zero register 0, optional same-cycle write-to-read bypass and a per-register scoreboard of pending writes. It sits between decode (read/reserve) and writeback (write/release) in the datapath. The scoreboard lets the control unit stall on read-after-write hazards.

---
 rtl/register_bank_sb.sv | 102 ++++++++++
 1 files changed

// File: rtl/register_bank_sb.sv
// Register file with two combinational read ports, one byte-enabled write port,
// optional hardwired-zero register 0, optional write-to-read bypass and a pending-write scoreboard.
module register_bank_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_W-1:0]     RA,
  input  logic [ADDR_W-1:0]     RB,
  output logic [DATA_W-1:0]     PRA,
  output logic [DATA_W-1:0]     PRB,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     WC,
  input  logic [DATA_W-1:0]     WPC,
  input  logic [DATA_W/8-1:0]   WBE,
  input  logic                  RSV,
  input  logic [ADDR_W-1:0]     RSV_ADDR,
  output logic                  BUSY_A,
  output logic                  BUSY_B
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int NB      = DATA_W / 8;
  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYP_EN  = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;

  logic              wr_ok;
  logic              rsv_ok;
  logic              hit_a;
  logic              hit_b;
  logic              rel_a;
  logic              rel_b;
  logic              zero_a;
  logic              zero_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] byp_a;
  logic [DATA_W-1:0] byp_b;
  logic [DATA_W-1:0] wr_merged;

  assign wr_ok  = WE && !(ZERO_EN && (WC == '0));
  assign rsv_ok = RSV && !(ZERO_EN && (RSV_ADDR == '0));

  assign rd_a = regs[RA];
  assign rd_b = regs[RB];

  // The same byte merge feeds the stored write and both bypass paths.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
      assign wr_merged[gi*8 +: 8] = WBE[gi] ? WPC[gi*8 +: 8] : regs[WC][gi*8 +: 8];
      assign byp_a[gi*8 +: 8]     = WBE[gi] ? WPC[gi*8 +: 8] : rd_a[gi*8 +: 8];
      assign byp_b[gi*8 +: 8]     = WBE[gi] ? WPC[gi*8 +: 8] : rd_b[gi*8 +: 8];
    end
  endgenerate

  // Reserve is applied after release so a new producer wins over the retiring one.
  always_comb begin
    busy_next = busy;
    if (WE) begin
      busy_next[WC] = 1'b0;
    end
    if (rsv_ok) begin
      busy_next[RSV_ADDR] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_ok) begin
        regs[WC] <= wr_merged;
      end
      busy <= busy_next;
    end
  end

  assign zero_a = ZERO_EN && (RA == '0);
  assign zero_b = ZERO_EN && (RB == '0);
  assign hit_a  = BYP_EN && WE && (WC == RA);
  assign hit_b  = BYP_EN && WE && (WC == RB);

  // A same-cycle release only hides busy when no fresh reserve targets that register.
  assign rel_a = hit_a && !(rsv_ok && (RSV_ADDR == RA));
  assign rel_b = hit_b && !(rsv_ok && (RSV_ADDR == RB));

  assign PRA    = zero_a ? '0 : (hit_a ? byp_a : rd_a);
  assign PRB    = zero_b ? '0 : (hit_b ? byp_b : rd_b);
  assign BUSY_A = !zero_a && busy[RA] && !rel_a;
  assign BUSY_B = !zero_b && busy[RB] && !rel_b;

endmodule
